// File: rtl/es_pipe_ctrl_pkg.sv
// Shared definitions for the DS->ES pipeline latch: bus widths, the
// positions of the load_op/dest fields inside the DS->ES payload, and the
// two-state view of the ES slot.
package es_pipe_ctrl_pkg;

    localparam int DS_TO_ES_BUS_WD = 150;
    localparam int ES_TO_LU_BUS_WD = 10;

    localparam int LOAD_OP_LSB = 0;
    localparam int LOAD_OP_WD  = 5;
    localparam int DEST_LSB    = 5;
    localparam int DEST_WD     = 5;

    // ES slot occupancy; a busy slot is simply FULL while es_op_done is low
    typedef enum logic {
        ES_EMPTY = 1'b0,
        ES_FULL  = 1'b1
    } es_slot_e;

endpackage

// File: rtl/es_perf_cnt.sv
// Two independently enabled, free-running wrapping counters used to observe
// load-use stall cycles and injected ES bubbles. Cleared only by reset.
module es_perf_cnt
    import es_pipe_ctrl_pkg::*;
#(
    parameter int CNT_WD = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_en_i,
    input  logic              bubble_en_i,
    output logic [CNT_WD-1:0] stall_cnt_o,
    output logic [CNT_WD-1:0] bubble_cnt_o
);

    logic [CNT_WD-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WD-1:0] bubble_cnt_q, bubble_cnt_d;

    // Increment each counter when its event fires; overflow wraps naturally
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (stall_en_i) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (bubble_en_i) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    // Counter registers, cleared by the synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: rtl/es_pipe_ctrl.sv
// Decode->execute pipeline latch and ES-stage flow control.
// Captures the DS payload on handshake, turns a load-use hazard into a
// single ES bubble while holding DS, and kills the ES slot on flush.
// Optional feature macro: ES_PERF_CNT_EN adds stall/bubble counters and
// their output ports; without it the design is otherwise identical.
module es_pipe_ctrl
    import es_pipe_ctrl_pkg::*;
#(
    parameter int BUS_WD = DS_TO_ES_BUS_WD,
    parameter int CNT_WD = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ds_to_es_valid,
    input  logic [BUS_WD-1:0]          ds_to_es_bus,
    output logic                       es_allowin,
    input  logic                       lu_stall,
    input  logic                       es_op_done,
    input  logic                       ms_allowin,
    input  logic                       flush,
    output logic                       es_valid,
    output logic [BUS_WD-1:0]          es_bus,
    output logic                       es_to_ms_valid,
    output logic [ES_TO_LU_BUS_WD-1:0] es_to_lu_bus
`ifdef ES_PERF_CNT_EN
    ,
    output logic [CNT_WD-1:0]          perf_stall_cnt,
    output logic [CNT_WD-1:0]          perf_bubble_cnt
`endif
);

    es_slot_e          state_q, state_d;
    logic [BUS_WD-1:0] es_bus_q, es_bus_d;

    logic es_ready_go;
    logic es_go;

    assign es_valid    = (state_q == ES_FULL);
    assign es_ready_go = es_op_done;
    // The slot can take a new entry when it is empty or its occupant leaves this cycle
    assign es_go       = !es_valid || (es_ready_go && ms_allowin);

    assign es_allowin     = es_go && !lu_stall && !flush;
    assign es_to_ms_valid = es_valid && es_ready_go && !flush;
    assign es_bus         = es_bus_q;

    // A dead or bubble slot must never look like a load to the hazard detector
    assign es_to_lu_bus = {es_bus_q[DEST_LSB +: DEST_WD],
                           es_valid ? es_bus_q[LOAD_OP_LSB +: LOAD_OP_WD] : {LOAD_OP_WD{1'b0}}};

    // Slot next-state: flush kills, a stall with a free slot injects a bubble,
    // otherwise the slot takes whatever DS offers; payload only moves on a real capture
    always_comb begin
        state_d  = state_q;
        es_bus_d = es_bus_q;
        if (flush) begin
            state_d = ES_EMPTY;
        end else if (es_go) begin
            if (lu_stall) begin
                state_d = ES_EMPTY;
            end else if (ds_to_es_valid) begin
                state_d  = ES_FULL;
                es_bus_d = ds_to_es_bus;
            end else begin
                state_d = ES_EMPTY;
            end
        end
    end

    // Slot state and payload registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ES_EMPTY;
            es_bus_q <= '0;
        end else begin
            state_q  <= state_d;
            es_bus_q <= es_bus_d;
        end
    end

`ifdef ES_PERF_CNT_EN
    logic stall_evt;
    logic bubble_evt;

    // A stall cycle is counted only when DS actually has something blocked
    assign stall_evt  = lu_stall && ds_to_es_valid && !flush;
    assign bubble_evt = es_go && lu_stall && !flush;

    es_perf_cnt #(
        .CNT_WD (CNT_WD)
    ) u_perf_cnt (
        .clk          (clk),
        .reset        (reset),
        .stall_en_i   (stall_evt),
        .bubble_en_i  (bubble_evt),
        .stall_cnt_o  (perf_stall_cnt),
        .bubble_cnt_o (perf_bubble_cnt)
    );
`else
    // No performance counters in this build
`endif

endmodule

// File: tb/tb_es_pipe_ctrl.sv
// Randomized self-checking bench for es_pipe_ctrl against a slot-occupancy
// reference model. Define ES_PERF_CNT_EN to also check the counters.
module tb_es_pipe_ctrl;
    import es_pipe_ctrl_pkg::*;

    localparam int BW = DS_TO_ES_BUS_WD;

    logic          clk;
    logic          reset;
    logic          ds_to_es_valid;
    logic [BW-1:0] ds_to_es_bus;
    logic          es_allowin;
    logic          lu_stall;
    logic          es_op_done;
    logic          ms_allowin;
    logic          flush;
    logic          es_valid;
    logic [BW-1:0] es_bus;
    logic          es_to_ms_valid;
    logic [9:0]    es_to_lu_bus;
`ifdef ES_PERF_CNT_EN
    logic [31:0]   perf_stall_cnt;
    logic [31:0]   perf_bubble_cnt;
`endif

    es_pipe_ctrl #(
        .BUS_WD (BW),
        .CNT_WD (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ds_to_es_valid (ds_to_es_valid),
        .ds_to_es_bus   (ds_to_es_bus),
        .es_allowin     (es_allowin),
        .lu_stall       (lu_stall),
        .es_op_done     (es_op_done),
        .ms_allowin     (ms_allowin),
        .flush          (flush),
        .es_valid       (es_valid),
        .es_bus         (es_bus),
        .es_to_ms_valid (es_to_ms_valid),
        .es_to_lu_bus   (es_to_lu_bus)
`ifdef ES_PERF_CNT_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: is there a live instruction in ES, what payload sits there,
    // and how many stall cycles / bubbles have been seen since reset
    bit          mOccupied;
    bit [BW-1:0] mPayload;
    bit [31:0]   mStalls;
    bit [31:0]   mBubbles;

    task automatic checkOutput(input string tag, input logic [BW-1:0] observed,
                               input logic [BW-1:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit dv, input logic [BW-1:0] db,
                                 input bit ls, input bit od, input bit ma, input bit fl);
        reset          = r;
        ds_to_es_valid = dv;
        ds_to_es_bus   = db;
        lu_stall       = ls;
        es_op_done     = od;
        ms_allowin     = ma;
        flush          = fl;
    endtask

    function automatic logic [BW-1:0] randBus();
        logic [BW-1:0] b;
        for (int w = 0; w < BW; w += 32) begin
            b = (b << 32) | BW'($urandom);
        end
        return b;
    endfunction

    bit            r, dv, ls, od, ma, fl;
    logic [BW-1:0] db;
    bit            leaves, canTake;
    bit [9:0]      expLu;

    initial begin
        // Hold reset for two cycles with DS offering an instruction
        applyStimulus(1'b1, 1'b1, randBus(), 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_es_valid", es_valid, 1'b0);
        checkOutput("reset_lu_bus", es_to_lu_bus, 10'h000);
        checkOutput("reset_to_ms_valid", es_to_ms_valid, 1'b0);
        checkOutput("reset_es_bus", es_bus, '0);
        checkOutput("reset_allowin", es_allowin, 1'b1);
        mOccupied = 1'b0;
        mPayload  = '0;
        mStalls   = '0;
        mBubbles  = '0;

        for (int cyc = 0; cyc < 600; cyc++) begin
            r  = ($urandom_range(0, 99) < 2);
            dv = ($urandom_range(0, 99) < 70);
            ls = ($urandom_range(0, 99) < 25);
            od = ($urandom_range(0, 99) < 70);
            ma = ($urandom_range(0, 99) < 75);
            fl = ($urandom_range(0, 99) < 8);
            db = randBus();
            applyStimulus(r, dv, db, ls, od, ma, fl);
            #1;

            // The occupant leaves when its result is ready and MS takes it
            leaves  = mOccupied && od && ma;
            canTake = !mOccupied || leaves;
            expLu   = {mPayload[9:5], mOccupied ? mPayload[4:0] : 5'b00000};
            checkOutput("allowin", es_allowin, canTake && !ls && !fl);
            checkOutput("to_ms_valid", es_to_ms_valid, mOccupied && od && !fl);
            checkOutput("lu_bus", es_to_lu_bus, expLu);

            if (r) begin
                mOccupied = 1'b0;
                mPayload  = '0;
                mStalls   = '0;
                mBubbles  = '0;
            end else begin
                if (ls && dv && !fl) mStalls++;
                if (fl) begin
                    mOccupied = 1'b0;
                end else if (canTake && ls) begin
                    mOccupied = 1'b0;
                    mBubbles++;
                end else if (canTake) begin
                    mOccupied = dv;
                    if (dv) mPayload = db;
                end
            end

            @(negedge clk);
            checkOutput("es_valid", es_valid, mOccupied);
            checkOutput("es_bus", es_bus, mPayload);
`ifdef ES_PERF_CNT_EN
            checkOutput("perf_stall", perf_stall_cnt, mStalls);
            checkOutput("perf_bubble", perf_bubble_cnt, mBubbles);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
